uart_receiver: RTL



---
 rtl/uart_receiver.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: two-flop synchroniser, centre-of-bit sampling, one-cycle
// valid/framing-error strobes and break suppression after a bad stop bit.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;

    logic             w_at_last;
    logic             w_shift_en;
    logic             w_good;
    logic             w_bad;

    assign w_at_last = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!r_rx_s) w_state_next = StStart;
            end
            StStart: begin
                // A start bit that is high again at its centre was only a glitch.
                if (r_cnt == CNT_HALF) w_state_next = r_rx_s ? StIdle : StData;
            end
            StData: begin
                if (w_at_last) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) w_state_next = StStop;
                end
            end
            StStop: begin
                if (w_at_last) begin
                    w_good       = r_rx_s;
                    w_bad        = !r_rx_s;
                    w_state_next = r_rx_s ? StIdle : StWaitHigh;
                end
            end
            StWaitHigh: begin
                if (r_rx_s) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_meta   <= RxD;
            r_rx_s      <= r_rx_meta;
            r_state     <= w_state_next;
            r_rx_valid  <= w_good;
            r_frame_err <= w_bad;

            // Counter restarts on every state entry and at each data-bit boundary.
            if (w_state_next != r_state || w_shift_en) begin
                r_cnt <= '0;
            end else if (r_state == StStart || r_state == StData || r_state == StStop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (r_state == StStart && w_state_next == StData) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_shift_en) r_shift[r_bit_idx] <= r_rx_s;
            if (w_good)     r_rx_data <= r_shift;
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != StIdle);

endmodule
